// File: rtl/nibble_cmp_pkg.sv
// Shared types for the nibble window tracker: FSM states, sample width and
// the three-way compare encoding produced by nibble_compare.
package nibble_cmp_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_e;

  // Folds the one-hot gt/eq/lt flags of a comparator into a single code.
  function automatic cmp_e cmp_encode(input logic gt, input logic eq, input logic lt);
    cmp_e res;
    case ({gt, eq, lt})
      3'b100:  res = CMP_GT;
      3'b001:  res = CMP_LT;
      default: res = CMP_EQ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/nibble_compare.sv
// Unsigned 4-bit magnitude compare; exactly one of gt/eq/lt is high.
module nibble_compare
  import nibble_cmp_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  output logic                gt,
  output logic                eq,
  output logic                lt
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/nibble_window_tracker.sv
// Groups a stream of 4-bit samples into WIN_LEN windows and reports
// max, min and rise/fall/equal step counts per window.
module nibble_window_tracker
  import nibble_cmp_pkg::*;
#(
  parameter int WIN_LEN = 8,
  parameter int CNT_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NIBBLE_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NIBBLE_W-1:0] out_max,
  output logic [NIBBLE_W-1:0] out_min,
  output logic [CNT_W-1:0]    out_rise,
  output logic [CNT_W-1:0]    out_fall,
  output logic [CNT_W-1:0]    out_eq
);

  state_e              state_q;
  logic [NIBBLE_W-1:0] max_q, min_q, prev_q;
  logic [CNT_W-1:0]    cnt_q, rise_q, fall_q, eq_q;

  logic [NIBBLE_W-1:0] max_d, min_d;
  logic [CNT_W-1:0]    cnt_d, rise_d, fall_d, eq_d;
  logic                accept, last_sample;

  logic p_gt, p_eq, p_lt;
  logic x_gt, x_eq, x_lt;
  logic n_gt, n_eq, n_lt;
  cmp_e cmp_prev, cmp_max, cmp_min;

  nibble_compare u_cmp_prev (.a(in_data), .b(prev_q), .gt(p_gt), .eq(p_eq), .lt(p_lt));
  nibble_compare u_cmp_max  (.a(in_data), .b(max_q),  .gt(x_gt), .eq(x_eq), .lt(x_lt));
  nibble_compare u_cmp_min  (.a(in_data), .b(min_q),  .gt(n_gt), .eq(n_eq), .lt(n_lt));

  assign cmp_prev = cmp_encode(p_gt, p_eq, p_lt);
  assign cmp_max  = cmp_encode(x_gt, x_eq, x_lt);
  assign cmp_min  = cmp_encode(n_gt, n_eq, n_lt);

  assign in_ready  = !rst && (state_q != REPORT);
  assign out_valid = (state_q == REPORT);
  assign accept    = in_valid && in_ready;

  // Window statistics as they would stand after accepting in_data now.
  always_comb begin
    max_d  = max_q;
    min_d  = min_q;
    rise_d = rise_q;
    fall_d = fall_q;
    eq_d   = eq_q;
    cnt_d  = cnt_q + CNT_W'(1);
    if (state_q == IDLE) begin
      max_d  = in_data;
      min_d  = in_data;
      rise_d = '0;
      fall_d = '0;
      eq_d   = '0;
      cnt_d  = CNT_W'(1);
    end else begin
      case (cmp_prev)
        CMP_GT:  rise_d = rise_q + CNT_W'(1);
        CMP_LT:  fall_d = fall_q + CNT_W'(1);
        default: eq_d   = eq_q + CNT_W'(1);
      endcase
      if (cmp_max == CMP_GT) max_d = in_data;
      if (cmp_min == CMP_LT) min_d = in_data;
    end
  end

  assign last_sample = (cnt_d == CNT_W'(WIN_LEN));

  // Result registers load only on the closing sample, so they stay frozen
  // through REPORT and until the next window completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      max_q    <= '0;
      min_q    <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      eq_q     <= '0;
      out_max  <= '0;
      out_min  <= '0;
      out_rise <= '0;
      out_fall <= '0;
      out_eq   <= '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            max_q  <= max_d;
            min_q  <= min_d;
            prev_q <= in_data;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            eq_q   <= eq_d;
            if (last_sample) begin
              out_max  <= max_d;
              out_min  <= min_d;
              out_rise <= rise_d;
              out_fall <= fall_d;
              out_eq   <= eq_d;
              state_q  <= REPORT;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        REPORT: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nibble_window_tracker.md
# nibble_window_tracker

Streaming stage that sits directly downstream of the 4-bit magnitude comparator logic. It accepts a stream of unsigned 4-bit samples over a valid/ready handshake and groups them into fixed windows of WIN_LEN samples. For each window it produces the maximum, the minimum, and counts of rising, falling and equal steps between consecutive samples. It feeds the window-level result to downstream logic over a second valid/ready handshake.

## Interface
- WIN_LEN, 8: samples per window; legal range 2..15.
- CNT_W, 4: width of step counters and the sample counter; must hold WIN_LEN.

- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  4  unsigned sample.
- out_valid  out  1  window result valid.
- out_ready  in  1  consumer accepts the result.
- out_max  out  4  largest sample in the window.
- out_min  out  4  smallest sample in the window.
- out_rise  out  CNT_W  count of steps where sample > previous sample.
- out_fall  out  CNT_W  count of steps where sample < previous sample.
- out_eq  out  CNT_W  count of steps where sample == previous sample.

## Operation
- Input accept = in_valid && in_ready. Output transfer = out_valid && out_ready.
- All comparisons are unsigned 4-bit.
- FSM states:
  - IDLE: in_ready=1. On accept, max=min=prev=in_data, sample count=1, and rise/fall/eq=0. The next state is ACCUM.
  - ACCUM: in_ready=1. On accept:
    - Compare in_data with prev and increment exactly one of rise, fall or eq.
    - If in_data > max, max=in_data. If in_data < min, min=in_data.
    - prev=in_data and count=count+1.
    - If the incremented count equals WIN_LEN, the next state is REPORT.
  - REPORT: in_ready=0, out_valid=1, and all out_* are held stable. On output transfer, the next state is IDLE.
- Invariant at REPORT: rise+fall+eq = WIN_LEN-1.
- Counters never wrap, because CNT_W bits are sufficient by parameter rule.
- in_valid asserted with in_ready=0 (in REPORT) is ignored. Upstream must hold the sample until it is accepted.
- out_ready asserted outside REPORT has no effect.
- In REPORT, the output transfer and the next input cannot occur in the same cycle. in_ready rises only in the cycle after the transfer.

## Timing
- Reset (async assert, sync release via clk): state=IDLE; out_valid=0; out_max, out_min, out_rise, out_fall, out_eq=0; internal prev and count=0. in_ready is 0 while rst is high and 1 in the first cycle after release.
- Latency: out_valid rises on the clock edge that accepts the WIN_LEN-th sample. The result is visible in the following cycle.
- Minimum window period: WIN_LEN+1 cycles, made of WIN_LEN accept cycles plus one REPORT cycle with out_ready held at 1.
- Outputs are registered. in_ready and out_valid are pure decodes of state (and rst).
- Reset mid-window or mid-REPORT discards the partial window. No result is emitted for it.

## Structure
- Shared package nibble_cmp_pkg:
  - state enum (IDLE, ACCUM, REPORT).
  - NIBBLE_W=4.
  - compare-result encoding (CMP_LT, CMP_EQ, CMP_GT).
- Sub-module nibble_compare: purely combinational, with a, b [3:0] in and gt, eq, lt out.
  - Three instances: in_data vs prev, in_data vs max, in_data vs min.
  - Exactly one of gt, eq, lt is high per instance.
- The top level contains the FSM, the count/step registers and the output registers.

## Test plan
- Stream 10,11,12,11,9,8,15,15 with WIN_LEN=8 and out_ready=1 → max=15, min=8, rise=3, fall=3, eq=1. out_valid is high exactly one cycle.
- Eight samples of 12 → max=12, min=12, rise=0, fall=0, eq=7.
- Hold out_ready=0 for 5 cycles after REPORT while in_valid=1 with data 3 → in_ready=0, outputs are stable, and no sample is consumed. Release out_ready, and the first sample of the next window is accepted one cycle later.
- Boundary values 0,15,0,15,0,15,0,15 → max=15, min=0, rise=4, fall=3, eq=0.
- Assert rst after the 4th sample of a window, then stream 1..8 → one result only: max=8, min=1, rise=7, fall=0, eq=0.
- Insert random in_valid gaps into the first test stream → the results are identical to the gap-free run.
